// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 constants and encodings used by the inverter front end and point units.
package secp256k1_pkg;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ZERO    = 2'b01,
    ERR_RANGE   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_BUSY,
    S_RESP
  } state_e;

endpackage

// File: rtl/mod_inv_arbiter_if.sv
// Requester-side request/response bundle of the modular-inverter arbiter.
interface mod_inv_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [256*NUM_REQ-1:0] req_operand;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [NUM_REQ-1:0]     resp_ready;
  logic [255:0]           resp_data;
  logic [1:0]             resp_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_operand, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

  // Requester side
  modport master (
    output req_valid, req_operand, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and binary id of the first
// requester after last_i (with wrap).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     id_o
);
  logic [IDW-1:0] idx;

  // Scan farthest-to-nearest so the last hit written is the nearest one after last_i
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    idx     = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      idx = IDW'((32'(last_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
  end
endmodule

// File: rtl/mod_inv_arbiter.sv
// mod_inv_arbiter: round-robin front end for the shared secp256k1 modular inverter.
// Screens operands, launches the inverter, supervises it with a timeout and
// returns result/error on the granted requester's response channel.
module mod_inv_arbiter #(
  parameter int unsigned  NUM_REQ        = 4,
  parameter int unsigned  TIMEOUT_CYCLES = 4096,
  parameter logic [255:0] P              = secp256k1_pkg::P
) (
  input  logic             clk,
  input  logic             reset,
  mod_inv_arbiter_if.slave req_if,
  output logic             inv_start,
  output logic [255:0]     inv_operand,
  input  logic             inv_done,
  input  logic [255:0]     inv_result,
  output logic             inv_abort,
  output logic             busy,
  output logic [31:0]      ops_done
);
  import secp256k1_pkg::*;

  localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e             state_q, state_d;
  err_e               err_q, err_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [IDW-1:0]     rr_last_q, rr_last_d;
  logic [IDW-1:0]     win_id;
  logic [NUM_REQ-1:0] grant;
  logic [255:0]       operand_q, operand_d;
  logic [255:0]       data_q, data_d;
  logic [255:0]       win_op;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [31:0]        ops_q, ops_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req_i   (req_if.req_valid),
    .last_i  (rr_last_q),
    .grant_o (grant),
    .id_o    (win_id)
  );

  assign win_op           = req_if.req_operand[256*win_id +: 256];
  assign req_if.req_ready = (state_q == S_IDLE) ? grant : '0;
  assign req_if.resp_data = data_q;
  assign req_if.resp_err  = err_q;
  assign inv_operand      = operand_q;
  assign busy             = (state_q != S_IDLE);
  assign ops_done         = ops_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_OK;
      gid_q     <= '0;
      rr_last_q <= IDW'(NUM_REQ - 1);
      operand_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      gid_q     <= gid_d;
      rr_last_q <= rr_last_d;
      operand_q <= operand_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ops_q     <= ops_d;
    end
  end

  // Next-state logic and inverter control strobes
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    gid_d     = gid_q;
    rr_last_d = rr_last_q;
    operand_d = operand_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    ops_d     = ops_q;
    inv_start = 1'b0;
    inv_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          operand_d = win_op;
          gid_d     = win_id;
          rr_last_d = win_id;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (operand_q == '0) begin
          err_d   = ERR_ZERO;
          data_d  = '0;
          state_d = S_RESP;
        end else if (operand_q >= P) begin
          err_d   = ERR_RANGE;
          data_d  = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        inv_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (inv_done) begin
          data_d  = inv_result;
          err_d   = ERR_OK;
          state_d = S_RESP;
        end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          inv_abort = 1'b1;
          data_d    = '0;
          err_d     = ERR_TIMEOUT;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (req_if.resp_ready[gid_q]) begin
          if (err_q == ERR_OK) ops_d = ops_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-hot response valid toward the granted requester
  always_comb begin
    req_if.resp_valid = '0;
    if (state_q == S_RESP) req_if.resp_valid[gid_q] = 1'b1;
  end
endmodule

// File: tb/tb_mod_inv_arbiter.sv
// Randomized self-checking bench for mod_inv_arbiter with a programmable-latency
// inverter stub and a transaction-level reference model.
module tb_mod_inv_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [255:0] PRIME =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] INV2 =
    256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

  logic         clk = 1'b0;
  logic         reset;
  logic         inv_start, inv_done, inv_abort, busy;
  logic [255:0] inv_operand, inv_result;
  logic [31:0]  ops_done;

  mod_inv_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  mod_inv_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TIMEOUT),
    .P              (PRIME)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (bus),
    .inv_start   (inv_start),
    .inv_operand (inv_operand),
    .inv_done    (inv_done),
    .inv_result  (inv_result),
    .inv_abort   (inv_abort),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Fermat inverse a^(p-2) mod p
  function automatic logic [255:0] modinv(input logic [255:0] a);
    logic [511:0] r, b, m;
    logic [255:0] e;
    r = 512'd1;
    b = {256'd0, a};
    m = {256'd0, PRIME};
    e = PRIME - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[255:0];
  endfunction

  // Inverter stub: done arrives stub_lat cycles after the start edge, never if hung
  int unsigned  stub_lat  = 0;
  bit           stub_hang = 1'b0;
  logic         stub_act  = 1'b0;
  int unsigned  stub_cnt  = 0;
  logic [255:0] stub_val  = '0;
  logic [255:0] garbage   = '0;

  always @(posedge clk) begin
    garbage <= rand256();
    if (reset) begin
      stub_act <= 1'b0;
      stub_cnt <= 0;
    end else if (inv_start) begin
      stub_act <= !stub_hang;
      stub_cnt <= stub_lat;
      stub_val <= modinv(inv_operand);
    end else if (inv_abort) begin
      stub_act <= 1'b0;
    end else if (stub_act) begin
      if (stub_cnt == 0) stub_act <= 1'b0;
      else               stub_cnt <= stub_cnt - 1;
    end
  end

  assign inv_done   = stub_act && (stub_cnt == 0);
  assign inv_result = inv_done ? stub_val : garbage;

  // Reference model state
  logic [255:0] opnd [NREQ];
  int           rr_last;
  int           exp_ops;
  logic [255:0] obs_data;

  function automatic int pick(input logic [NREQ-1:0] vmask);
    for (int off = 1; off <= int'(NREQ); off++) begin
      int i;
      i = (rr_last + off) % NREQ;
      if (vmask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [255:0] rand_op();
    int sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       return '0;
      1:       return PRIME;
      2:       return PRIME + 256'($urandom_range(1, 1000));
      3:       return '1;
      default: return rand256() % PRIME;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 256'({bus.req_ready, bus.resp_valid, bus.resp_err,
                               busy, inv_start, inv_abort}), '0);
    check({tag, "_data"}, bus.resp_data, '0);
    check({tag, "_invop"}, inv_operand, '0);
    check({tag, "_ops"}, 256'(ops_done), '0);
  endtask

  // One full transaction; entered and left at a negedge with the DUT idle
  task automatic run_op(input logic [NREQ-1:0] vmask, input int rdy_delay);
    int w, exp_k, starts, aborts, abort_k;
    bit launched;
    logic [255:0] op, exp_data;
    logic [1:0] exp_err;
    logic [NREQ-1:0] oh;
    w = pick(vmask);
    if (w < 0) return;
    oh = '0;
    oh[w] = 1'b1;
    op = opnd[w];
    if (op == '0) begin
      exp_err = 2'b01; exp_data = '0; exp_k = 1;
    end else if (op >= PRIME) begin
      exp_err = 2'b10; exp_data = '0; exp_k = 1;
    end else if (stub_hang) begin
      exp_err = 2'b11; exp_data = '0; exp_k = TIMEOUT + 2;
    end else begin
      exp_err = 2'b00; exp_data = modinv(op); exp_k = int'(stub_lat) + 3;
    end
    launched = (exp_err == 2'b00) || (exp_err == 2'b11);

    bus.req_valid = vmask;
    for (int i = 0; i < int'(NREQ); i++) bus.req_operand[256*i +: 256] = opnd[i];
    #1;
    check("grant", 256'(bus.req_ready), 256'(oh));
    @(posedge clk);
    rr_last = w;

    starts = 0; aborts = 0; abort_k = -1;
    for (int k = 0; k < exp_k; k++) begin
      @(negedge clk);
      check("wait", 256'({bus.resp_valid, bus.req_ready, !busy}), '0);
      if (inv_start) starts++;
      if (inv_abort) begin aborts++; abort_k = k; end
      if (launched && k >= 1) check("inv_operand", inv_operand, op);
    end

    @(negedge clk);
    check("resp_valid", 256'(bus.resp_valid), 256'(oh));
    check("resp_data", bus.resp_data, exp_data);
    check("resp_err", 256'(bus.resp_err), 256'(exp_err));
    check("inv_start_cnt", 256'(starts), 256'(launched));
    check("inv_abort_cnt", 256'(aborts), 256'(exp_err == 2'b11));
    if (exp_err == 2'b11) check("abort_cycle", 256'(abort_k), 256'(TIMEOUT + 1));
    obs_data = bus.resp_data;

    for (int d = 0; d < rdy_delay; d++) begin
      bus.resp_ready = NREQ'($urandom) & ~oh;
      @(negedge clk);
      check("hold_data", bus.resp_data, exp_data);
      check("hold_ctl", 256'({bus.resp_valid, bus.resp_err, bus.req_ready}),
            256'({oh, exp_err, {NREQ{1'b0}}}));
    end
    bus.resp_ready = NREQ'($urandom) | oh;
    @(negedge clk);
    bus.resp_ready = '0;
    if (exp_err == 2'b00) exp_ops++;
    check("post_idle", 256'({bus.resp_valid, busy, inv_start, inv_abort}), '0);
    check("ops_done", 256'(ops_done), 256'(exp_ops));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_operand = '0;
    bus.resp_ready  = '0;
    rr_last         = NREQ - 1;
    exp_ops         = 0;
    for (int i = 0; i < int'(NREQ); i++) opnd[i] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Requester 1, operand 2, latency 10
    opnd[1] = 256'd2;
    stub_lat = 10;
    run_op(4'b0010, 0);
    check("inv2_value", obs_data, INV2);

    // All requesters valid continuously: strict rotation
    for (int i = 0; i < int'(NREQ); i++) opnd[i] = rand256() % PRIME;
    stub_lat = 2;
    repeat (5) run_op(4'b1111, 0);

    // Operand screening
    opnd[2] = '0;               run_op(4'b0100, 0);
    opnd[2] = PRIME;            run_op(4'b0100, 0);
    opnd[2] = PRIME + 256'd1;   run_op(4'b0100, 0);
    opnd[0] = '1;               run_op(4'b0001, 1);
    opnd[0] = PRIME - 256'd1;   run_op(4'b0001, 0);

    // Timeout, then normal service
    opnd[3] = rand256() % PRIME;
    stub_hang = 1'b1;
    run_op(4'b1000, 1);
    stub_hang = 1'b0;
    stub_lat = 4;
    run_op(4'b1000, 0);

    // Done coinciding with the last timeout cycle, and one cycle before it
    opnd[0] = rand256() % PRIME;
    stub_lat = 15; run_op(4'b0001, 0);
    stub_lat = 14; run_op(4'b0001, 0);
    stub_lat = 0;  run_op(4'b0001, 0);

    // Response back-pressure with competing requests pending
    for (int i = 0; i < int'(NREQ); i++) opnd[i] = rand256() % PRIME;
    stub_lat = 3;
    run_op(4'b1111, 20);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < int'(NREQ); i++) opnd[i] = rand_op();
      stub_hang = ($urandom_range(0, 7) == 0);
      stub_lat  = $urandom_range(0, 15);
      run_op(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
    stub_hang = 1'b0;

    // Reset while the inverter is busy
    opnd[2] = 256'd5;
    stub_lat = 10;
    bus.req_valid = 4'b0100;
    bus.req_operand[256*2 +: 256] = opnd[2];
    #1;
    check("rst_grant", 256'(bus.req_ready), 256'(4'b0100));
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("rst_busy_pre", 256'(busy), 256'(1'b1));
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    check_zero("rst_mid");
    reset = 1'b0;
    rr_last = NREQ - 1;
    exp_ops = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("rst_no_resp", 256'({bus.resp_valid, busy, inv_start, inv_abort}), '0);
    end

    // Priority restarts at requester 0
    opnd[0] = 256'd7;
    opnd[1] = 256'd9;
    stub_lat = 3;
    run_op(4'b0011, 0);
    run_op(4'b0011, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mod_inv_arbiter.md
Name: mod_inv_arbiter

Overview:
Shares the single 256-bit modular inverter (mod p, secp256k1 prime) between NUM_REQ requesters, such as the point-add and point-double units. It grants requesters round-robin and screens operands (zero or out of range). It launches the inverter with a one-cycle start pulse, supervises it with a timeout, and returns the result or an error code through a per-requester valid/ready response. It sits between the EC point units and the inverter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, maximum cycles allowed from start pulse to inverter done
P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_operand  in  256*NUM_REQ  flattened operands; requester i uses bits [256*i+255:256*i]
req_ready  out  NUM_REQ  one-hot accept
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-requester response ready
resp_data  out  256  inverse; 0 on error
resp_err  out  2  00 ok, 01 zero operand, 10 operand >= P, 11 timeout
inv_start  out  1  one-cycle start pulse to inverter
inv_operand  out  256  operand to inverter; stable from start until done or abort
inv_done  in  1  inverter completion; sampled in BUSY only
inv_result  in  256  inverter result, valid when inv_done=1
inv_abort  out  1  one-cycle pulse on timeout; ORed into the inverter's reset by the integrator
busy  out  1  high in every state except IDLE
ops_done  out  32  count of ok responses; wraps modulo 2^32

Behaviour:
- Reset values, applied synchronously: state=IDLE, all outputs 0, rr_last=NUM_REQ-1 so that requester 0 has first priority, timeout counter 0, ops_done 0.
- Reset mid-operation: return to IDLE with no response delivered. inv_abort stays 0; the inverter shares reset.
- FSM states: IDLE, CHECK, LAUNCH, BUSY, RESP.
- IDLE:
  - req_ready is combinational and one-hot on the winner: the first i with req_valid[i] searching from rr_last+1 with wrap.
  - Handshake is req_valid & req_ready. On handshake, latch the operand and grant id g, then go to CHECK.
  - rr_last is updated to g on acceptance.
- CHECK, 1 cycle:
  - operand==0 -> err=01, go to RESP.
  - operand>=P -> err=10, go to RESP.
  - Otherwise go to LAUNCH.
- LAUNCH, 1 cycle: inv_start=1 and inv_operand=latched operand. Clear the counter, then go to BUSY.
- BUSY: the counter increments each cycle.
  - inv_done=1 -> capture inv_result, err=00, go to RESP.
  - Otherwise, counter==TIMEOUT_CYCLES-1 -> inv_abort=1 for that cycle, err=11, go to RESP.
  - If done and expiry occur in the same cycle, done wins.
- RESP:
  - resp_valid[g]=1. resp_data and resp_err are held stable until resp_ready[g].
  - On handshake: increment ops_done if err=00, then go to IDLE.
  - resp_ready from other requesters is ignored.
- Latency, ok path: accept -> response valid = 3 + inverter cycles.
- Latency, error paths: zero/range error is 1 cycle after accept.
- Only one operation is in flight; req_ready is 0 outside IDLE.
- A new request from the just-served requester is accepted only if no other requester is valid (fairness).
- inv_start is never asserted outside LAUNCH.

Decomposition:
- Shared package secp256k1_pkg:
  - the P constant, shared with the inverter and point units
  - the resp_err codes: ERR_OK, ERR_ZERO, ERR_RANGE, ERR_TIMEOUT
  - the FSM state encodings
- One natural sub-module, rr_arbiter: parameterised NUM_REQ, takes req vector and last-grant pointer, returns one-hot grant plus binary id. It is combinational and reusable by the point-unit multiplier arbiter.

Test Plan (NUM_REQ=4, behavioural inverter stub with programmable latency):
- Requester 1 sends operand 2, stub latency 10 -> one inv_start pulse with inv_operand=2; resp_valid[1] at 13 cycles after accept; resp_data=0x7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18; err=00; ops_done=1.
- All four requesters valid continuously -> grants in order 0,1,2,3,0; no requester is starved; req_ready is never multi-hot.
- Operand 0, then operand P, then operand P+1 -> err=01, 10, 10 respectively; inv_start is never pulsed; each response arrives 1 cycle after accept.
- Stub never asserts done, TIMEOUT_CYCLES=16 -> inv_abort pulses once, 16 cycles after inv_start; err=11; next request is served normally.
- resp_ready held low for 20 cycles -> resp_valid, resp_data and resp_err are stable throughout; no new req_ready until the handshake completes.
- Reset asserted while in BUSY -> next cycle state is IDLE and all outputs are 0; the pending requester gets no response; ops_done=0.
